// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_pkg
//  Description : Shared types and constants for the LC-3 memory/IO responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Default memory-mapped I/O address (switches in / hex display out)
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Width of the SRAM wait-cycle counter
    localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_io_regs.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_regs
//  Description : Hex display register and read-data select (switches vs SRAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_regs (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hex_load_i,
    input  logic [15:0] hex_data_i,
    input  logic        io_sel_i,
    input  logic [15:0] sw_i,
    input  logic [15:0] sram_data_i,
    output logic [15:0] hex_o,
    output logic [15:0] rd_data_o
);

    logic [15:0] hex_q;

    // Display register: loaded only by an I/O write, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hex_q <= 16'h0000;
        end else if (hex_load_i) begin
            hex_q <= hex_data_i;
        end
    end

    assign hex_o     = hex_q;
    // Read source: switches for an I/O read, otherwise the SRAM data bus
    assign rd_data_o = io_sel_i ? sw_i : sram_data_i;

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_responder
//  Description : MAR/MDR memory responder: async SRAM with programmable wait
//                cycles, one memory-mapped I/O address, one-cycle ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MDR_In,
    output logic        R,
    input  logic [15:0] SW,
    output logic [15:0] HEX_Data,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam logic [CNT_W-1:0] c_WAIT = WAIT_CYCLES[CNT_W-1:0];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      addr_q;
    logic [15:0]      data_q;
    logic             wr_q;
    logic [15:0]      mdr_in_q;
    logic             r_q;
    logic             ce_n_q;
    logic             oe_n_q;
    logic             we_n_q;

    logic             w_req;
    logic             w_is_io;
    logic             w_hex_load;
    logic             w_io_sel;
    logic [15:0]      w_rd_data;

    assign w_req      = MEM_RD | MEM_WR;
    assign w_is_io    = (MAR == IO_ADDR);
    // A simultaneous read+write request is treated as a write
    assign w_hex_load = (state_q == IDLE) && w_req && w_is_io && MEM_WR;
    // Switches are only read on the accepting edge in IDLE
    assign w_io_sel   = (state_q == IDLE);

    mem_io_regs u_regs (
        .clk_i       (Clk),
        .rst_i       (Reset_ah),
        .hex_load_i  (w_hex_load),
        .hex_data_i  (MDR),
        .io_sel_i    (w_io_sel),
        .sw_i        (SW),
        .sram_data_i (SRAM_DQ_in),
        .hex_o       (HEX_Data),
        .rd_data_o   (w_rd_data)
    );

    // Request sequencing, wait counting and registered SRAM strobes
    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            wr_q     <= 1'b0;
            mdr_in_q <= 16'h0000;
            r_q      <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_req) begin
                        addr_q <= MAR;
                        data_q <= MDR;
                        wr_q   <= MEM_WR;
                        if (w_is_io) begin
                            // I/O completes at this edge; display load is in u_regs
                            if (!MEM_WR) begin
                                mdr_in_q <= w_rd_data;
                            end
                            r_q     <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= c_WAIT;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= MEM_WR;
                            we_n_q  <= ~MEM_WR;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (!wr_q) begin
                            mdr_in_q <= w_rd_data;
                        end
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        r_q     <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Wait for the CPU to drop its level request so it is not serviced twice
                    if (!w_req) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MDR_In      = mdr_in_q;
    assign R           = r_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = data_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_io_responder
//  Description : Directed self-checking bench for mem_io_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    logic        Clk = 1'b0;
    logic        Reset_ah = 1'b1;
    logic        MEM_RD = 1'b0;
    logic        MEM_WR = 1'b0;
    logic [15:0] MAR = 16'h0000;
    logic [15:0] MDR = 16'h0000;
    logic [15:0] SW = 16'h0000;
    logic [15:0] MDR_In, HEX_Data, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_in;
    logic        R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    // Second instance with zero wait cycles
    logic        rd0 = 1'b0;
    logic        wr0 = 1'b0;
    logic [15:0] MAR0 = 16'h0000;
    logic [15:0] MDR0 = 16'h0000;
    logic [15:0] dq_in0;
    logic [15:0] MDR_In0, HEX0, ADDR0, DQ_out0;
    logic        R0, CE0_N, OE0_N, WE0_N;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];

    always #5 Clk = ~Clk;

    mem_io_responder #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .MAR(MAR), .MDR(MDR), .MDR_In(MDR_In), .R(R), .SW(SW), .HEX_Data(HEX_Data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    mem_io_responder #(.WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
        .Clk(Clk), .Reset_ah(Reset_ah), .MEM_RD(rd0), .MEM_WR(wr0),
        .MAR(MAR0), .MDR(MDR0), .MDR_In(MDR_In0), .R(R0), .SW(SW), .HEX_Data(HEX0),
        .SRAM_ADDR(ADDR0), .SRAM_DQ_out(DQ_out0), .SRAM_DQ_in(dq_in0),
        .SRAM_CE_N(CE0_N), .SRAM_OE_N(OE0_N), .SRAM_WE_N(WE0_N)
    );

    assign dq_in0 = 16'h0000;

    // SRAM model (low 8 address bits); preloaded while reset is held
    always @(posedge Clk) begin
        if (Reset_ah) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h40] <= 16'hBEEF;
            mem[8'h00] <= 16'h1357;
        end else if (!SRAM_CE_N && !SRAM_WE_N) begin
            mem[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
        end
    end
    assign SRAM_DQ_in = mem[SRAM_ADDR[7:0]];

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic start(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(posedge Clk);
        #1;
        MEM_RD = rd;
        MEM_WR = wr;
        MAR    = a;
        MDR    = d;
    endtask

    task automatic drop();
        @(posedge Clk);
        #1;
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
        rd0    = 1'b0;
        wr0    = 1'b0;
    endtask

    int rcnt;
    int oecnt;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge Clk);
        #1 Reset_ah = 1'b0;
        cyc();
        check16("rst_mdr_in", MDR_In, 16'h0000);
        check16("rst_hex", HEX_Data, 16'h0000);
        check16("rst_addr", SRAM_ADDR, 16'h0000);
        check16("rst_dq_out", SRAM_DQ_out, 16'h0000);
        check1("rst_r", R, 1'b0);
        check1("rst_ce_n", SRAM_CE_N, 1'b1);
        check1("rst_oe_n", SRAM_OE_N, 1'b1);
        check1("rst_we_n", SRAM_WE_N, 1'b1);

        // ---------------- SRAM read, 2 wait cycles ----------------
        start(1'b1, 1'b0, 16'h0040, 16'h0000);
        cyc();
        check1("rd_c0_ce_n", SRAM_CE_N, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            check1("rd_acc_oe_n", SRAM_OE_N, 1'b0);
            check1("rd_acc_ce_n", SRAM_CE_N, 1'b0);
            check1("rd_acc_we_n", SRAM_WE_N, 1'b1);
            check1("rd_acc_r", R, 1'b0);
            check16("rd_acc_addr", SRAM_ADDR, 16'h0040);
        end
        cyc();
        check1("rd_c4_r", R, 1'b1);
        check1("rd_c4_oe_n", SRAM_OE_N, 1'b1);
        check16("rd_c4_mdr_in", MDR_In, 16'hBEEF);
        drop();
        cyc();
        check1("rd_c5_r", R, 1'b0);

        // ---------------- SRAM write, inputs changed after latch ----------------
        start(1'b0, 1'b1, 16'h1234, 16'h5A5A);
        cyc();
        for (int c = 1; c <= 3; c++) begin
            cyc();
            MAR = 16'hDEAD;
            MDR = 16'h0000;
            check1("wr_acc_we_n", SRAM_WE_N, 1'b0);
            check1("wr_acc_oe_n", SRAM_OE_N, 1'b1);
            check16("wr_acc_addr", SRAM_ADDR, 16'h1234);
            check16("wr_acc_dq", SRAM_DQ_out, 16'h5A5A);
        end
        cyc();
        check1("wr_c4_r", R, 1'b1);
        check1("wr_c4_we_n", SRAM_WE_N, 1'b1);
        check16("wr_mdr_in_kept", MDR_In, 16'hBEEF);
        drop();

        // read back
        start(1'b1, 1'b0, 16'h1234, 16'h0000);
        repeat (5) cyc();
        check1("rb_c4_r", R, 1'b1);
        check16("rb_mdr_in", MDR_In, 16'h5A5A);
        drop();

        // ---------------- I/O write then I/O read ----------------
        start(1'b0, 1'b1, 16'hFFFF, 16'h00C3);
        cyc();
        check16("io_c0_hex", HEX_Data, 16'h0000);
        cyc();
        check16("io_wr_hex", HEX_Data, 16'h00C3);
        check1("io_wr_r", R, 1'b1);
        check1("io_wr_ce_n", SRAM_CE_N, 1'b1);
        check1("io_wr_we_n", SRAM_WE_N, 1'b1);
        check16("io_wr_mdr_in", MDR_In, 16'h5A5A);
        drop();

        SW = 16'h0081;
        start(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        cyc();
        cyc();
        check16("io_rd_mdr_in", MDR_In, 16'h0081);
        check1("io_rd_r", R, 1'b1);
        check1("io_rd_oe_n", SRAM_OE_N, 1'b1);
        check16("io_rd_hex", HEX_Data, 16'h00C3);
        drop();

        // ---------------- held read request for 10 cycles ----------------
        rcnt  = 0;
        oecnt = 0;
        start(1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (R) rcnt++;
            if (!SRAM_OE_N) oecnt++;
        end
        check16("held_r_pulses", 16'(rcnt), 16'd1);
        check16("held_oe_cycles", 16'(oecnt), 16'd3);
        check16("held_mdr_in", MDR_In, 16'hBEEF);
        drop();

        // ---------------- write accepted right after drop, reset mid-access ----------------
        start(1'b0, 1'b1, 16'h0180, 16'h7777);
        cyc();
        cyc();
        check1("rst_wr_c1_we_n", SRAM_WE_N, 1'b0);
        @(posedge Clk);
        #1;
        Reset_ah = 1'b1;
        MEM_WR   = 1'b0;
        @(posedge Clk);
        #1;
        Reset_ah = 1'b0;
        cyc();
        check1("abort_we_n", SRAM_WE_N, 1'b1);
        check1("abort_ce_n", SRAM_CE_N, 1'b1);
        check1("abort_r", R, 1'b0);
        check16("abort_mdr_in", MDR_In, 16'h0000);
        check16("abort_hex", HEX_Data, 16'h0000);
        cyc();
        check1("abort_r_next", R, 1'b0);

        start(1'b1, 1'b0, 16'h0000, 16'h0000);
        repeat (5) cyc();
        check1("post_rst_r", R, 1'b1);
        check16("post_rst_mdr_in", MDR_In, 16'h1357);
        drop();

        // ---------------- zero wait cycles, simultaneous RD+WR ----------------
        @(posedge Clk);
        #1;
        rd0  = 1'b1;
        wr0  = 1'b1;
        MAR0 = 16'h0022;
        MDR0 = 16'hABCD;
        cyc();
        check1("w0_c0_we_n", WE0_N, 1'b1);
        cyc();
        check1("w0_c1_we_n", WE0_N, 1'b0);
        check1("w0_c1_oe_n", OE0_N, 1'b1);
        check1("w0_c1_r", R0, 1'b0);
        check16("w0_c1_dq", DQ_out0, 16'hABCD);
        cyc();
        check1("w0_c2_we_n", WE0_N, 1'b1);
        check1("w0_c2_r", R0, 1'b1);
        check16("w0_mdr_in", MDR_In0, 16'h0000);
        drop();
        cyc();
        check1("w0_c3_r", R0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory interface. Accepts read/write requests from the CPU control unit, drives an external asynchronous SRAM with a programmable number of wait cycles, decodes the memory-mapped I/O address (switches in, hex display out), and returns read data on `MDR_In` with a one-cycle ready pulse `R`. Sits between the CPU datapath and the board SRAM/IO pins.

## Interface
- `WAIT_CYCLES`, 2: extra SRAM access cycles beyond the first; 0–15 legal.
- `IO_ADDR`, 16'hFFFF: memory-mapped I/O address; never forwarded to SRAM.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset_ah`  in  1  reset, synchronous and active-high.
- `MEM_RD`  in  1  CPU read request, level, held until `R` seen.
- `MEM_WR`  in  1  CPU write request, level, held until `R` seen.
- `MAR`  in  16  request address.
- `MDR`  in  16  write data.
- `MDR_In`  out  16  read data to the CPU MDR input mux.
- `R`  out  1  ready; one-cycle pulse on completion.
- `SW`  in  16  board switches, read at `IO_ADDR`.
- `HEX_Data`  out  16  display register, written at `IO_ADDR`.
- `SRAM_ADDR`  out  16  SRAM address.
- `SRAM_DQ_out`  out  16  SRAM write data.
- `SRAM_DQ_in`  in  16  SRAM read data.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`  out  1 each  active-low SRAM strobes.

## Operation
- States: `IDLE`, `ACCESS`, `DONE`, `HOLD`.
- **IDLE:** on `MEM_RD|MEM_WR`:
  - Latch `MAR`, `MDR` and op. If both requests are high, op is write.
  - If address == `IO_ADDR`, perform the I/O op at this edge and go to `DONE`:
    - Write: `HEX_Data <= MDR`.
    - Read: `MDR_In <= SW`.
  - Otherwise load `cnt <= WAIT_CYCLES` and go to `ACCESS`.
- **ACCESS:**
  - `SRAM_CE_N=0`; `SRAM_ADDR` and `SRAM_DQ_out` come from the latches.
  - `SRAM_OE_N=0` for a read; `SRAM_WE_N=0` for a write.
  - While `cnt!=0`, decrement `cnt`.
  - When `cnt==0`:
    - Read: `MDR_In <= SRAM_DQ_in`.
    - Go to `DONE`.
- **DONE:** `R=1` for exactly one cycle, all strobes deasserted, then go to `HOLD`.
- **HOLD:** wait until `MEM_RD==0 && MEM_WR==0`, then go to `IDLE`. This prevents a held request from being serviced twice.
- `MDR_In` holds the last completed read value. Writes never change it.
- `MAR`/`MDR` changes after the latch edge are ignored until the next request.

## Timing
- Request first visible in cycle 0, state `IDLE`.
  - SRAM access: `ACCESS` occupies cycles 1..`WAIT_CYCLES`+1; `R=1` in cycle `WAIT_CYCLES`+2; read data valid on `MDR_In` from that cycle.
  - I/O access: `R=1` in cycle 1; `HEX_Data`/`MDR_In` updated from cycle 1.
- Strobes are registered outputs: they assert in the first `ACCESS` cycle and deassert in `DONE`. `SRAM_ADDR` is stable throughout `ACCESS`.
- Earliest next acceptance is the cycle after the requests drop in `HOLD` (back-to-back minimum: one `HOLD` cycle plus one `IDLE` cycle).
- Reset values: state `IDLE`, `MDR_In=0`, `R=0`, `HEX_Data=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`, all `*_N=1`, `cnt=0`.
- Reset mid-access aborts the access:
  - Strobes are high from the cycle after the reset edge.
  - No `R` pulse, no `MDR_In` or `HEX_Data` update.
- Reset has priority over every state transition.

## Structure
- Package `mem_io_pkg`:
  - `state_t` enum (`IDLE`, `ACCESS`, `DONE`, `HOLD`).
  - Constant `IO_ADDR_DEFAULT = 16'hFFFF`.
  - Constant `CNT_W = 4`.
- Sub-module `mem_io_regs` holds the `HEX_Data` register and the `SW` read path, with a load enable and a read-select. The FSM, counter and SRAM drive stay in the top module.

## Test plan
- SRAM read, `WAIT_CYCLES=2`: preload model `[16'h0040]=16'hBEEF`; assert `MEM_RD`, `MAR=16'h0040` in cycle 0.
  - `OE_N`/`CE_N` low in cycles 1–3.
  - `R=1` in cycle 4 only.
  - `MDR_In=16'hBEEF`.
- SRAM write: `MEM_WR`, `MAR=16'h1234`, `MDR=16'h5A5A`.
  - `WE_N` low for 3 cycles with `SRAM_ADDR=16'h1234`, `SRAM_DQ_out=16'h5A5A`.
  - Read back returns `16'h5A5A`.
  - `MDR_In` unchanged by the write.
- I/O: write `16'h00C3` to `16'hFFFF` → `HEX_Data=16'h00C3` in cycle 1, `R` in cycle 1, no SRAM strobe. Then `SW=16'h0081` and read `16'hFFFF` → `MDR_In=16'h0081`.
- Held request: keep `MEM_RD` high for 10 cycles → exactly one `R` pulse and one access. Drop `MEM_RD` → `IDLE` next cycle.
- Reset in the second `ACCESS` cycle of a write → strobes high next cycle, no `R`; subsequent read of `16'h0000` from the reset state works.
- `WAIT_CYCLES=0` with simultaneous `MEM_RD`/`MEM_WR` → treated as a write; `WE_N` low for 1 cycle; `R` in cycle 2.
